// File: rtl/toggle_event_decoder.sv
// Receive side of a toggle-level event link: synchronises t_in, turns every level
// change into one queued event and hands events out on a valid/ready handshake.
module toggle_event_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int PEND_W      = 4,
    parameter int SEQ_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t_in,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [SEQ_W-1:0]  evt_seq,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic [SEQ_W-1:0]  drop_cnt,
    input  logic              clr_ovf
);

    localparam int                CNT_W     = 3;
    localparam logic [CNT_W-1:0]  INIT_LAST = CNT_W'(SYNC_STAGES);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [SEQ_W-1:0]  DROP_MAX  = '1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0]  s_q, s_d;
    logic                    prev_q, prev_d;
    logic [PEND_W-1:0]       pending_q, pending_d;
    logic [SEQ_W-1:0]        seq_q, seq_d;
    logic                    ovf_q, ovf_d;
    logic [SEQ_W-1:0]        drop_q, drop_d;

    logic s_last;
    logic edge_det;
    logic count_edge;
    logic pop;
    logic drop;

    // s[0] is the first (metastability-exposed) stage; s[last] feeds edge detection
    assign s_d[0] = t_in;
    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign s_d[gi] = s_q[gi-1];
        end
    endgenerate

    assign s_last     = s_q[SYNC_STAGES-1];
    assign edge_det   = s_last ^ prev_q;
    assign count_edge = (state_q == ST_RUN) && edge_det;
    assign pop        = evt_valid && evt_ready;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        prev_d     = s_last;
        pending_d  = pending_q;
        seq_d      = seq_q;
        ovf_d      = ovf_q;
        drop_d     = drop_q;
        drop       = 1'b0;

        // INIT lets the chain fill and prev track it, so a static level is never an event
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    init_cnt_d = init_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (count_edge && !pop) begin
            if (pending_q == PEND_MAX) begin
                drop = 1'b1;
            end else begin
                pending_d = pending_q + PEND_W'(1);
            end
        end else if (!count_edge && pop) begin
            pending_d = pending_q - PEND_W'(1);
        end

        if (pop) begin
            seq_d = seq_q + SEQ_W'(1);
        end

        // A drop in the same cycle as a clear restarts the count at one
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf) begin
                drop_d = SEQ_W'(1);
            end else if (drop_q != DROP_MAX) begin
                drop_d = drop_q + SEQ_W'(1);
            end
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            s_q        <= '0;
            prev_q     <= 1'b0;
            pending_q  <= '0;
            seq_q      <= '0;
            ovf_q      <= 1'b0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            s_q        <= s_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            seq_q      <= seq_d;
            ovf_q      <= ovf_d;
            drop_q     <= drop_d;
        end
    end

    assign evt_valid = (pending_q != '0);
    assign evt_seq   = seq_q;
    assign pending   = pending_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder at default parameters (2 sync stages,
// 15-deep pending queue, 8-bit sequence and drop counters).
module tb_toggle_event_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       t_in;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_seq;
    logic [3:0] pending;
    logic       overflow;
    logic [7:0] drop_cnt;
    logic       clr_ovf;

    int n_compared   = 0;
    int n_mismatched = 0;

    toggle_event_decoder #(
        .SYNC_STAGES(2),
        .PEND_W     (4),
        .SEQ_W      (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .t_in     (t_in),
        .evt_valid(evt_valid),
        .evt_ready(evt_ready),
        .evt_seq  (evt_seq),
        .pending  (pending),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (8) tick();
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " valid"},    32'(evt_valid), 32'd0);
        check_val({tag, " pending"},  32'(pending),   32'd0);
        check_val({tag, " seq"},      32'(evt_seq),   32'd0);
        check_val({tag, " overflow"}, 32'(overflow),  32'd0);
        check_val({tag, " drop_cnt"}, 32'(drop_cnt),  32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        t_in      = 1'b1;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;

        // Static high level through reset must not create an event
        repeat (3) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_val("t_in high valid", 32'(evt_valid), 32'd0);
        end
        check_reset_state("post reset");

        // Single toggle: sampled at edge n, visible after edge n+2
        t_in = 1'b0;
        tick();
        check_val("lat n pending", 32'(pending), 32'd0);
        tick();
        check_val("lat n+1 pending", 32'(pending), 32'd0);
        tick();
        check_val("lat n+2 pending", 32'(pending), 32'd1);
        check_val("lat n+2 valid", 32'(evt_valid), 32'd1);
        check_val("lat seq before pop", 32'(evt_seq), 32'd0);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_val("single pop pending", 32'(pending), 32'd0);
        check_val("single pop seq", 32'(evt_seq), 32'd1);
        check_val("single pop valid", 32'(evt_valid), 32'd0);

        // Burst of 5 with backpressure, then drain one per cycle
        do_reset();
        for (int i = 0; i < 5; i++) begin
            t_in = ~t_in;
            repeat (3) tick();
        end
        repeat (3) tick();
        check_val("burst pending", 32'(pending), 32'd5);
        evt_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check_val($sformatf("drain%0d seq", i), 32'(evt_seq), 32'(i));
            check_val($sformatf("drain%0d pending", i), 32'(pending), 32'(5 - i));
            check_val($sformatf("drain%0d valid", i), 32'(evt_valid), (i < 5) ? 32'd1 : 32'd0);
        end
        evt_ready = 1'b0;

        // Overflow: 18 events into a 15-deep queue drops 3
        do_reset();
        for (int i = 0; i < 18; i++) begin
            t_in = ~t_in;
            tick();
        end
        repeat (4) tick();
        check_val("ovf pending", 32'(pending), 32'd15);
        check_val("ovf flag", 32'(overflow), 32'd1);
        check_val("ovf drop_cnt", 32'(drop_cnt), 32'd3);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_val("clr flag", 32'(overflow), 32'd0);
        check_val("clr drop_cnt", 32'(drop_cnt), 32'd0);
        check_val("clr pending", 32'(pending), 32'd15);

        // Edge coinciding with a pop at full is not a drop
        t_in = ~t_in;
        tick();
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        check_val("full push+pop pending", 32'(pending), 32'd15);
        check_val("full push+pop overflow", 32'(overflow), 32'd0);
        check_val("full push+pop seq", 32'(evt_seq), 32'd1);

        // Drop in the same cycle as clr_ovf: drop wins
        t_in = ~t_in;
        tick();
        tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_val("drop vs clr overflow", 32'(overflow), 32'd1);
        check_val("drop vs clr drop_cnt", 32'(drop_cnt), 32'd1);

        // drop_cnt saturates at 255
        for (int i = 0; i < 260; i++) begin
            t_in = ~t_in;
            tick();
        end
        repeat (4) tick();
        check_val("drop_cnt saturate", 32'(drop_cnt), 32'd255);
        check_val("sat pending", 32'(pending), 32'd15);

        // Sequence wrap through 256 toggle/pop pairs
        do_reset();
        evt_ready = 1'b1;
        for (int i = 0; i < 255; i++) begin
            t_in = ~t_in;
            repeat (2) tick();
        end
        repeat (4) tick();
        check_val("seq at 255", 32'(evt_seq), 32'd255);
        t_in = ~t_in;
        repeat (6) tick();
        check_val("seq wrap", 32'(evt_seq), 32'd0);
        check_val("wrap pending", 32'(pending), 32'd0);
        evt_ready = 1'b0;

        // Mid-run reset discards queued events
        for (int i = 0; i < 3; i++) begin
            t_in = ~t_in;
            tick();
        end
        repeat (4) tick();
        check_val("pre-rst pending", 32'(pending), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_state("mid reset");
        // A change sampled at the first edge after release falls inside INIT
        t_in = ~t_in;
        repeat (8) tick();
        check_val("init absorb pending", 32'(pending), 32'd0);
        t_in = ~t_in;
        repeat (2) tick();
        check_val("post init n+1 pending", 32'(pending), 32'd0);
        tick();
        check_val("post init n+2 pending", 32'(pending), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
